fifo_write_arbiter: RTL

Round-robin arbiter sharing the single write port of the team's asynchronous FIFO among NUM_REQ requesters in the write clock domain. Each requester presents beats with a valid/ready handshake. The arbiter grants one requester at a time for a burst of up to MAX_BURST beats, then rotates priority. It drives the FIFO write enable and data, and honours the FIFO full flag beat by beat.

---
 rtl/fifo_write_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that shares one asynchronous-FIFO write port among NUM_REQ
// requesters, granting bursts of up to MAX_BURST beats and honouring the full flag.
module fifo_write_arbiter #(
    parameter int BITS      = 32,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                       write_clk,
    input  logic                       write_rst_n,
    input  logic [NUM_REQ-1:0]         p_req_valid,
    input  logic [NUM_REQ*BITS-1:0]    p_req_data,
    input  logic [NUM_REQ-1:0]         p_req_last,
    output logic [NUM_REQ-1:0]         p_req_ready,
    output logic                       p_fifo_write_en,
    output logic [BITS-1:0]            p_fifo_write_data,
    input  logic                       p_fifo_write_full,
    output logic                       p_grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] p_grant_id
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [IDW-1:0] r_grant_id;
    logic [IDW-1:0] r_last_grant;
    logic [IDW-1:0] w_winner;
    logic [CW-1:0]  r_cnt;
    logic           w_sel_valid;
    logic           w_sel_last;
    logic           w_accept;
    logic           w_burst_end;

    // Scan from the farthest offset down so the nearest requester after last_grant wins;
    // offset NUM_REQ is last_grant itself, which therefore has the lowest priority.
    function automatic logic [IDW-1:0] pick_winner(input logic [NUM_REQ-1:0] req,
                                                   input logic [IDW-1:0]     last);
        logic [IDW-1:0] win;
        int             idx;
        win = last;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (req[IDW'(idx)]) win = IDW'(idx);
        end
        return win;
    endfunction

    assign w_winner          = pick_winner(p_req_valid, r_last_grant);
    assign w_sel_valid       = p_req_valid[r_grant_id];
    assign w_sel_last        = p_req_last[r_grant_id];
    assign p_fifo_write_data = p_req_data[int'(r_grant_id)*BITS +: BITS];
    assign p_grant_valid     = (r_state == BURST);
    assign p_grant_id        = r_grant_id;

    always_comb begin
        w_state_nxt     = r_state;
        p_req_ready     = '0;
        p_fifo_write_en = 1'b0;
        w_accept        = 1'b0;
        w_burst_end     = 1'b0;
        case (r_state)
            IDLE: begin
                if (|p_req_valid) w_state_nxt = BURST;
            end
            BURST: begin
                p_req_ready[r_grant_id] = !p_fifo_write_full;
                w_accept                = w_sel_valid && !p_fifo_write_full;
                p_fifo_write_en         = w_accept;
                // A withdrawn valid ends the burst even while the FIFO is full.
                w_burst_end = !w_sel_valid ||
                              (w_accept && (w_sel_last || r_cnt == CW'(MAX_BURST - 1)));
                if (w_burst_end) w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            r_state      <= IDLE;
            r_grant_id   <= '0;
            r_last_grant <= IDW'(NUM_REQ - 1);
            r_cnt        <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && |p_req_valid) begin
                r_grant_id <= w_winner;
                r_cnt      <= '0;
            end
            if (w_accept) r_cnt <= r_cnt + 1'b1;
            if (w_burst_end) r_last_grant <= r_grant_id;
        end
    end

endmodule
